f_dp_pipe: RTL and testbench

// - Next-generation formant-cost DP stage. Per frame i, for k=1..K: F(k,i)=min_j E(j+1,i)+F(k-1,j); B(k,i)=argmin j.
// - Reads E_min/F tables through a fixed-latency request port and writes F(k,i)/B(k,i) to the F/B stores.
// - Fully pipelined: one j candidate per cycle, no bubble between k (F(k-1,j), j<i, is from earlier frames).

---
 rtl/f_dp_pipe_if.sv | 39 +++
 rtl/f_dp_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_f_dp_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/f_dp_pipe_if.sv
// Handshake/bus bundle for the formant-cost DP stage.
// master: frame control and table read data; slave: the DP stage itself.
interface f_dp_pipe_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int FORMANTS  = 5
);
    localparam int IW = $clog2(I);
    localparam int KW = $clog2(FORMANTS + 1);
    localparam int JW = IW + 1;

    logic                 begin_iter;
    logic [IW-1:0]        i;
    logic [KW-1:0]        k_max;
    logic                 tie_latest;
    logic [BIT_WIDTH-1:0] e_prev;
    logic [BIT_WIDTH-1:0] f_prev;
    logic                 req_valid;
    logic [KW-1:0]        k_req;
    logic [JW-1:0]        j_req;
    logic                 output_valid;
    logic [KW-1:0]        k_write;
    logic [BIT_WIDTH-1:0] f_data;
    logic [JW-1:0]        b_data;
    logic                 iter_done;
    logic                 busy;

    modport master (
        output begin_iter, i, k_max, tie_latest, e_prev, f_prev,
        input  req_valid, k_req, j_req, output_valid, k_write,
        input  f_data, b_data, iter_done, busy
    );

    modport slave (
        input  begin_iter, i, k_max, tie_latest, e_prev, f_prev,
        output req_valid, k_req, j_req, output_valid, k_write,
        output f_data, b_data, iter_done, busy
    );
endinterface

// File: rtl/f_dp_pipe.sv
// Formant-cost DP stage: F(k,i)=min_j E(j+1,i)+F(k-1,j), B(k,i)=argmin j.
// Issues one table read per cycle (k=1..K_eff, j=k-2..i-1), consumes the
// returned E/F READ_LATENCY cycles later and writes F/B once per layer.
// Ports: clk_in, rst_n_in (async, active-low); bus (f_dp_pipe_if.slave):
//   begin_iter/i/k_max/tie_latest in, e_prev/f_prev read data in,
//   req_valid/k_req/j_req read request, output_valid/k_write/f_data/b_data
//   write strobe, iter_done final-write pulse, busy frame in progress.
// Option: F_SATURATE_EN clamps E+F to all-ones (INF); otherwise it wraps.
module f_dp_pipe #(
    parameter int BIT_WIDTH    = 32,
    parameter int I            = 160,
    parameter int FORMANTS     = 5,
    parameter int READ_LATENCY = 2
) (
    input logic        clk_in,
    input logic        rst_n_in,
    f_dp_pipe_if.slave bus
);
    localparam int IW = $clog2(I);
    localparam int KW = $clog2(FORMANTS + 1);
    localparam int JW = IW + 1;
    localparam logic [BIT_WIDTH-1:0] INF = {BIT_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic          valid;
        logic          first;
        logic          last;
        logic          fin;
        logic [KW-1:0] k;
        logic [JW-1:0] j;
    } tag_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [JW-1:0]        j_q, j_d;
    logic [IW-1:0]        i_q, i_d;
    logic [KW-1:0]        keff_q, keff_d;
    logic                 tie_q, tie_d;
    logic [KW-1:0]        kclamp, keff_in;
    logic                 req, first_j, last_j, fin_k;
    tag_t                 tag_d, tail;
    tag_t                 tag_q [READ_LATENCY];
    logic [BIT_WIDTH-1:0] acc_q, acc_n, base_acc, sum_c, cost;
    logic [JW-1:0]        bacc_q, b_n, base_b;
    logic                 take;
    logic                 ov_q, done_q;
    logic [KW-1:0]        kw_q;
    logic [BIT_WIDTH-1:0] fd_q;
    logic [JW-1:0]        bd_q;

    // Effective layer count: k_max clamped to [1,FORMANTS], then to i+1.
    always_comb begin
        kclamp = bus.k_max;
        if (bus.k_max == '0)
            kclamp = KW'(1);
        else if (32'(bus.k_max) > FORMANTS)
            kclamp = KW'(FORMANTS);
        keff_in = kclamp;
        if (32'(kclamp) > 32'(bus.i) + 32'd1)
            keff_in = KW'(32'(bus.i) + 32'd1);
    end

    assign first_j = (j_q == JW'(k_q) - JW'(2));
    assign last_j  = (j_q == JW'(i_q) - JW'(1));
    assign fin_k   = (k_q == keff_q);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        i_d     = i_q;
        keff_d  = keff_q;
        tie_d   = tie_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.begin_iter) begin
                    state_d = ISSUE;
                    i_d     = bus.i;
                    keff_d  = keff_in;
                    tie_d   = bus.tie_latest;
                    k_d     = KW'(1);
                    j_d     = '1;
                end
            end
            ISSUE: begin
                req = 1'b1;
                if (last_j) begin
                    if (fin_k) begin
                        state_d = DRAIN;
                    end else begin
                        // Next layer starts at j = (k+1)-2 = k-1.
                        k_d = k_q + KW'(1);
                        j_d = JW'(k_q) - JW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DRAIN: begin
                if (tail.valid && tail.last && tail.fin)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_d       = '0;
        tag_d.valid = req;
        tag_d.first = first_j;
        tag_d.last  = last_j;
        tag_d.fin   = fin_k;
        tag_d.k     = k_q;
        tag_d.j     = j_q;
    end

    assign tail = tag_q[READ_LATENCY-1];

`ifdef F_SATURATE_EN
    logic [BIT_WIDTH:0] sum_w;
    always_comb begin
        sum_w = {1'b0, bus.e_prev} + {1'b0, bus.f_prev};
        if (bus.e_prev == INF || bus.f_prev == INF || sum_w[BIT_WIDTH])
            sum_c = INF;
        else
            sum_c = sum_w[BIT_WIDTH-1:0];
    end
`else
    assign sum_c = bus.e_prev + bus.f_prev;
`endif

    // Layer 1 only has the j=-1 candidate (F(0,-1)=0); every other j is INF.
    // An INF candidate never moves the argmin, so all-INF leaves b=k-2.
    always_comb begin
        if (tail.k == KW'(1))
            cost = (tail.j == '1) ? bus.e_prev : INF;
        else
            cost = sum_c;
        base_acc = tail.first ? INF : acc_q;
        base_b   = tail.first ? JW'(tail.k) - JW'(2) : bacc_q;
        take     = (cost < base_acc) ||
                   (tie_q && cost == base_acc && cost != INF);
        acc_n    = take ? cost : base_acc;
        b_n      = take ? tail.j : base_b;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            i_q     <= '0;
            keff_q  <= '0;
            tie_q   <= 1'b0;
            for (int n = 0; n < READ_LATENCY; n++)
                tag_q[n] <= '0;
            acc_q   <= '0;
            bacc_q  <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
            kw_q    <= '0;
            fd_q    <= '0;
            bd_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            j_q      <= j_d;
            i_q      <= i_d;
            keff_q   <= keff_d;
            tie_q    <= tie_d;
            tag_q[0] <= tag_d;
            for (int n = 1; n < READ_LATENCY; n++)
                tag_q[n] <= tag_q[n-1];
            if (tail.valid) begin
                acc_q  <= acc_n;
                bacc_q <= b_n;
            end
            ov_q   <= tail.valid && tail.last;
            done_q <= tail.valid && tail.last && tail.fin;
            if (tail.valid && tail.last) begin
                kw_q <= tail.k;
                fd_q <= acc_n;
                bd_q <= b_n;
            end
        end
    end

    assign bus.req_valid    = req;
    assign bus.k_req        = req ? k_q : '0;
    assign bus.j_req        = req ? j_q : '0;
    assign bus.busy         = (state_q != IDLE);
    assign bus.output_valid = ov_q;
    assign bus.k_write      = kw_q;
    assign bus.f_data       = fd_q;
    assign bus.b_data       = bd_q;
    assign bus.iter_done    = done_q;
endmodule

// File: tb/tb_f_dp_pipe.sv
// Bench for f_dp_pipe: directed frames plus random frames scored against
// a loop-level DP model and a fixed-latency table memory.
module tb_f_dp_pipe;
    localparam int BW = 32;
    localparam int NI = 160;
    localparam int FORMANTS = 5;
    localparam int RL = 2;
    localparam bit [31:0] INF = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    bit [31:0] etab [NI+1];
    bit [31:0] ftab [FORMANTS][NI];

    f_dp_pipe_if #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(FORMANTS)) bus ();

    f_dp_pipe #(
        .BIT_WIDTH(BW), .I(NI), .FORMANTS(FORMANTS), .READ_LATENCY(RL)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Table memory: a request seen in cycle t is answered during t+RL.
    bit dv [RL+1];
    int dk [RL+1];
    int dj [RL+1];
    always @(negedge clk) begin
        for (int n = RL; n > 0; n--) begin
            dv[n] = dv[n-1];
            dk[n] = dk[n-1];
            dj[n] = dj[n-1];
        end
        dv[0] = bus.req_valid;
        dk[0] = int'(bus.k_req);
        dj[0] = int'($signed(bus.j_req));
        bus.e_prev = dv[RL] ? etab[dj[RL]+1] : $urandom;
        bus.f_prev = (dv[RL] && dk[RL] >= 2) ? ftab[dk[RL]-1][dj[RL]]
                                             : $urandom;
    end

    function automatic bit [31:0] cadd(input bit [31:0] a, input bit [31:0] b);
`ifdef F_SATURATE_EN
        longint s;
        s = longint'(a) + longint'(b);
        if (a == INF || b == INF || s > longint'(INF)) return INF;
        return s[31:0];
`else
        return a + b;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_tables(input int maxv);
        for (int n = 0; n <= NI; n++) etab[n] = $urandom_range(0, maxv);
        for (int k = 0; k < FORMANTS; k++)
            for (int n = 0; n < NI; n++) ftab[k][n] = $urandom_range(0, maxv);
    endtask

    task automatic run_frame(input int fi, input int fk, input bit ft,
                             input bit pre, input bit chain,
                             input int ni, input int nk, input bit nt);
        int keff, w, nreq, fr, lr;
        bit done;
        bit [31:0] ef[$];
        int eb[$];
        int rk[$];
        int rj[$];
        keff = (fk < 1) ? 1 : ((fk > FORMANTS) ? FORMANTS : fk);
        if (keff > fi + 1) keff = fi + 1;
        for (int k = 1; k <= keff; k++) begin
            bit [31:0] best;
            bit [31:0] c;
            int bj;
            best = INF;
            bj = k - 2;
            for (int j = k - 2; j <= fi - 1; j++) begin
                rk.push_back(k);
                rj.push_back(j);
                if (k == 1) c = (j == -1) ? etab[0] : INF;
                else c = cadd(etab[j+1], ftab[k-1][j]);
                if (c < best || (ft && c == best && c != INF)) begin
                    best = c;
                    bj = j;
                end
            end
            ef.push_back(best);
            eb.push_back(bj);
        end
        if (!pre) begin
            @(negedge clk);
            bus.begin_iter = 1'b1;
            bus.i = 8'(fi);
            bus.k_max = 3'(fk);
            bus.tie_latest = ft;
        end
        @(negedge clk);
        bus.begin_iter = 1'b0;
        bus.i = 8'($urandom_range(0, NI-1));
        bus.k_max = 3'($urandom);
        bus.tie_latest = 1'($urandom);
        check("busy_start", bus.busy, 1);
        w = 0; nreq = 0; fr = -1; lr = -1; done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (cyc == 1) bus.begin_iter = 1'b1;
            if (cyc == 2) bus.begin_iter = 1'b0;
            if (bus.req_valid) begin
                if (fr < 0) fr = cyc;
                lr = cyc;
                if (nreq < rk.size()) begin
                    check("req_k", bus.k_req, rk[nreq]);
                    check("req_j", int'($signed(bus.j_req)), rj[nreq]);
                end
                nreq++;
            end
            if (bus.output_valid) begin
                if (w < keff) begin
                    check("k_write", bus.k_write, w + 1);
                    check("f_data", bus.f_data, ef[w]);
                    check("b_data", int'($signed(bus.b_data)), eb[w]);
                    check("done_flag", bus.iter_done, (w == keff - 1));
                end
                w++;
                if (bus.iter_done) begin
                    done = 1'b1;
                    check("done_latency", cyc, lr + RL + 1);
                    check("writes", w, keff);
                    check("busy_end", bus.busy, 0);
                    check("req_count", nreq, rk.size());
                    check("req_gapless", lr - fr + 1, nreq);
                    if (chain) begin
                        bus.begin_iter = 1'b1;
                        bus.i = 8'(ni);
                        bus.k_max = 3'(nk);
                        bus.tie_latest = nt;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        check("frame_finished", done, 1);
    endtask

    initial begin
        bit seen;
        bus.begin_iter = 1'b0;
        bus.i = '0;
        bus.k_max = '0;
        bus.tie_latest = 1'b0;
        fill_tables(30);
        repeat (3) @(negedge clk);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_out_valid", bus.output_valid, 0);
        check("rst_iter_done", bus.iter_done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_f_data", bus.f_data, 0);
        check("rst_b_data", bus.b_data, 0);
        check("rst_k_write", bus.k_write, 0);
        rst_n = 1'b1;

        etab[0] = 7;
        run_frame(0, 5, 0, 0, 0, 0, 0, 0);

        etab[0] = 9; etab[1] = 4; etab[2] = 6; etab[3] = 2;
        ftab[1][0] = 1; ftab[1][1] = 1; ftab[1][2] = 5;
        run_frame(3, 2, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 5; n++) begin
            etab[n+1] = 5;
            ftab[1][n] = 5;
        end
        run_frame(5, 2, 0, 0, 0, 0, 0, 0);
        run_frame(5, 2, 1, 0, 0, 0, 0, 0);

        etab[0] = 3;
        etab[1] = 32'hFFFF_FFF0;
        ftab[1][0] = 32'h20;
        run_frame(1, 2, 0, 0, 0, 0, 0, 0);

        etab[0] = INF;
        run_frame(4, 1, 1, 0, 0, 0, 0, 0);

        fill_tables(30);
        run_frame(10, 0, 0, 0, 0, 0, 0, 0);
        run_frame(10, 7, 1, 0, 0, 0, 0, 0);
        run_frame(2, 5, 0, 0, 0, 0, 0, 0);

        run_frame(4, 3, 0, 0, 1, 6, 2, 1);
        run_frame(6, 2, 1, 1, 0, 0, 0, 0);

        etab[0] = 3;
        @(negedge clk);
        bus.begin_iter = 1'b1;
        bus.i = 8'd0;
        bus.k_max = 3'd1;
        @(negedge clk);
        bus.begin_iter = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_req_valid", bus.req_valid, 0);
        check("abort_out_valid", bus.output_valid, 0);
        check("abort_iter_done", bus.iter_done, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_f_data", bus.f_data, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.output_valid | bus.iter_done;
        end
        check("abort_no_write", seen, 0);
        run_frame(3, 2, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            fill_tables($urandom_range(3, 1000));
            run_frame($urandom_range(0, 40), $urandom_range(0, 7),
                      1'($urandom), 0, 0, 0, 0, 0);
        end
        fill_tables(100000);
        run_frame(NI - 1, 5, 1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
